// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: holds all resets, then releases them lowest index first.
// Optional ext_rst_in debounce filter enabled by defining DARKC_RST_GEN_DEBOUNCE_EN.
module rst_seq_gen #(
  parameter int NUM_OUT         = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ext_rst_in,
  input  logic               sw_rst_req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic [NUM_OUT-1:0] rst_n_out,
  output logic               ready,
  output logic [1:0]         cause
);

  generate
    if (NUM_OUT < 1 || NUM_OUT > 16 || HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
        STAGE_GAP < 1 || STAGE_GAP > 255 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
      $error("rst_seq_gen: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {ASSERT, RELEASE, RUN} state_t;

  state_t             state, state_nxt;
  logic [15:0]        hold_cnt, hold_nxt;
  logic [7:0]         gap_cnt, gap_nxt;
  logic [4:0]         stage, stage_nxt;
  logic [NUM_OUT-1:0] rst_out_nxt;
  logic               ready_nxt;
  logic [1:0]         cause_nxt;
  logic               ext_q;
  logic               trig;

`ifdef DARKC_RST_GEN_DEBOUNCE_EN
  logic [7:0] db_cnt;

  // Saturates at DEBOUNCE_CYCLES-1 so a held request stays qualified.
  always_ff @(posedge clk) begin
    if (rst || !ext_rst_in)
      db_cnt <= '0;
    else if (db_cnt != 8'(DEBOUNCE_CYCLES-1))
      db_cnt <= db_cnt + 8'd1;
  end

  assign ext_q = ext_rst_in && (db_cnt == 8'(DEBOUNCE_CYCLES-1));
`else
  assign ext_q = ext_rst_in;
`endif

  assign trig = rst | sw_rst_req | ext_q;

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    gap_nxt     = gap_cnt;
    stage_nxt   = stage;
    rst_out_nxt = rst_out;
    ready_nxt   = ready;
    cause_nxt   = cause;
    if (trig) begin
      state_nxt   = ASSERT;
      hold_nxt    = '0;
      gap_nxt     = '0;
      stage_nxt   = '0;
      rst_out_nxt = '1;
      ready_nxt   = 1'b0;
      cause_nxt   = rst ? 2'b00 : (ext_q ? 2'b01 : 2'b10);
    end else begin
      case (state)
        ASSERT: begin
          if (hold_cnt == 16'(HOLD_CYCLES-1)) begin
            state_nxt   = RELEASE;
            hold_nxt    = '0;
            gap_nxt     = '0;
            stage_nxt   = '0;
            rst_out_nxt = {NUM_OUT{1'b1}} << 1;
          end else begin
            hold_nxt = hold_cnt + 16'd1;
          end
        end
        RELEASE: begin
          // stage holds the index of the most recently released output
          if (stage == 5'(NUM_OUT-1)) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else if (gap_cnt == 8'(STAGE_GAP-1)) begin
            gap_nxt     = '0;
            stage_nxt   = stage + 5'd1;
            rst_out_nxt = rst_out << 1;
          end else begin
            gap_nxt = gap_cnt + 8'd1;
          end
        end
        RUN: ;
        default: begin
          state_nxt   = ASSERT;
          rst_out_nxt = '1;
          ready_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ASSERT;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      stage     <= '0;
      rst_out   <= '1;
      rst_n_out <= '0;
      ready     <= 1'b0;
      cause     <= 2'b00;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      gap_cnt   <= gap_nxt;
      stage     <= stage_nxt;
      rst_out   <= rst_out_nxt;
      rst_n_out <= ~rst_out_nxt;
      ready     <= ready_nxt;
      cause     <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen at default parameters (debounce macro off).
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ext_rst_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [3:0] rst_out, rst_n_out;
  logic       ready;
  logic [1:0] cause;

  int total = 0;
  int bad   = 0;
  bit inv_en = 1'b0;

  rst_seq_gen dut (
    .clk(clk), .rst(rst), .ext_rst_in(ext_rst_in), .sw_rst_req(sw_rst_req),
    .rst_out(rst_out), .rst_n_out(rst_n_out), .ready(ready), .cause(cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected rst_out i edges after the last trigger edge (hold 16, gap 4).
  function automatic logic [3:0] exp_rst(input int i);
    if (i < 16)      return 4'b1111;
    else if (i < 20) return 4'b1110;
    else if (i < 24) return 4'b1100;
    else if (i < 28) return 4'b1000;
    else             return 4'b0000;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic r, input logic s, input logic e);
    rst = r; sw_rst_req = s; ext_rst_in = e;
    step();
    rst = 1'b0; sw_rst_req = 1'b0; ext_rst_in = 1'b0;
  endtask

  task automatic run_seq(input logic [1:0] ec);
    for (int i = 1; i <= 30; i++) begin
      step();
      chk("seq_rst", rst_out, exp_rst(i));
      chk("seq_rdy", ready, (i >= 29));
    end
    chk("seq_cause", cause, ec);
  endtask

  always @(negedge clk) begin
    if (inv_en) begin
      logic [3:0] inv;
      logic [2:0] viol;
      inv  = ~rst_out;
      viol = rst_out[2:0] & ~rst_out[3:1];
      chk("inv_n", rst_n_out, inv);
      chk("inv_thermo", viol, 3'b000);
      if (ready) chk("inv_rdy", rst_out, 4'b0000);
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_out", rst_out, 4'b1111);
    chk("rst_n", rst_n_out, 4'b0000);
    chk("rst_rdy", ready, 1'b0);
    chk("rst_cause", cause, 2'b00);
    inv_en = 1'b1;
    rst = 1'b0;
    run_seq(2'b00);

    pulse(1'b0, 1'b1, 1'b0);
    chk("sw_rst", rst_out, 4'b1111);
    chk("sw_rdy", ready, 1'b0);
    chk("sw_cause", cause, 2'b10);
    run_seq(2'b10);

    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) step();
    chk("abort_pre", rst_out, 4'b1100);
    pulse(1'b0, 1'b1, 1'b0);
    chk("abort_rst", rst_out, 4'b1111);
    chk("abort_rdy", ready, 1'b0);
    run_seq(2'b10);

    pulse(1'b0, 1'b0, 1'b1);
    chk("ext_rst", rst_out, 4'b1111);
    chk("ext_cause", cause, 2'b01);
    run_seq(2'b01);

    pulse(1'b0, 1'b1, 1'b1);
    chk("co_sw_ext", cause, 2'b01);
    pulse(1'b1, 1'b1, 1'b0);
    chk("co_rst_sw", cause, 2'b00);
    pulse(1'b0, 1'b1, 1'b0);
    chk("co_sw", cause, 2'b10);
    pulse(1'b1, 1'b0, 1'b1);
    chk("co_rst_ext", cause, 2'b00);
    run_seq(2'b00);

    inv_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
